if_stage_ctrl: RTL and testbench
================================

Name: if_stage_ctrl

Overview:
- Front-end fetch controller: owns the PC register and the IF/ID pipeline register, and drives the instruction-memory read port.
- Consumes the stall / IFID_Write / PCWrite triple from hazard detection and the branch redirect from EX.
- Holds, advances, bubbles or flushes the front end each cycle, and keeps saturating performance counters for stalls, flushes and memory waits.

Parameters:
- ADDR_W, 32, PC and instruction address width in bits.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_write  in  1  from hazard detection; 0 holds the PC.
- ifid_write  in  1  from hazard detection; 0 holds IF/ID.
- stall  in  1  from hazard detection; used for accounting only.
- branch_taken  in  1  EX-stage redirect request.
- branch_target  in  ADDR_W  redirect address, word aligned.
- imem_addr  out  ADDR_W  fetch address, equals pc_q.
- imem_rd  out  1  fetch request.
- imem_data  in  32  instruction; combinational read of imem_addr.
- imem_rdy  in  1  imem_data valid this cycle.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_inst  out  32  IF/ID instruction.
- ifid_pc  out  ADDR_W  address of ifid_inst.
- stall_cnt  out  CNT_W  cycles with stall=1, excluding flush cycles.
- flush_cnt  out  CNT_W  branch redirects taken.
- wait_cnt  out  CNT_W  cycles a fetch was refused (imem_rdy=0).

Behaviour:
- Reset, synchronous, active-high; while rst=1 the following hold next edge:
  - pc_q=RESET_PC, ifid_valid=0, ifid_inst=NOP_INST (32'hE1A0_0000), ifid_pc=0.
  - All counters=0; state=BOOT.
  - Reset mid-operation discards all state identically; no partial updates.
- State machine, 2 states:
  - BOOT: imem_rd=0, IF/ID and PC unchanged; go to FETCH next cycle unconditionally. Guarantees one quiet cycle after reset release.
  - FETCH: imem_rd=1; stays in FETCH until rst.
- Per-cycle priority in FETCH (first match wins):
  1. branch_taken=1:
     - pc_q<=branch_target; ifid_valid<=0; ifid_inst<=NOP_INST; flush_cnt+1.
     - Overrides pc_write=0, ifid_write=0 and imem_rdy=0.
     - stall_cnt does not count this cycle.
  2. Otherwise pc_write and ifid_write are obeyed independently:
     - pc_write=0: PC holds.
     - ifid_write=0: IF/ID holds all three fields.
  3. pc_write=1, imem_rdy=0:
     - PC holds; wait_cnt+1.
     - If ifid_write=1: ifid_valid<=0 and ifid_inst<=NOP_INST (bubble).
  4. pc_write=1, imem_rdy=1:
     - pc_q<=pc_q+4, wrapping modulo 2^ADDR_W.
     - If ifid_write=1: ifid_valid<=1, ifid_inst<=imem_data, ifid_pc<=pc_q.
     - If ifid_write=0: the fetched instruction is dropped; the PC still advances. This is a legal but mismatched input pair.
- stall_cnt increments when stall=1 and branch_taken=0, in any state.
- Counters saturate at all-ones; no wrap.
- Latency: fetch to IF/ID is 1 cycle; redirect to new fetch address is 1 cycle; a flush costs exactly one bubble in IF/ID.
- branch_target low 2 bits are ignored and forced to 0.

Decomposition:
- Shared package arm_fe_pkg: NOP_INST constant, fe_state_t enum {BOOT, FETCH}, RESET_PC default.
- One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output count). Instantiated three times.

Test Plan:
- Reset release: rst high 3 cycles, then low, imem_rdy=1 -> BOOT cycle has imem_rd=0; next cycle imem_addr=0x0; IF/ID gets inst@0x0 with ifid_pc=0x0; PC sequence is 0x0, 0x4, 0x8.
- Load-use stall: pc_write=ifid_write=0, stall=1 for 1 cycle at pc=0x8 -> PC stays 0x8 and IF/ID is unchanged for that cycle; stall_cnt=1; fetch resumes at 0x8.
- Branch during stall: branch_taken=1, target=0x100, same cycle as stall=1 -> next pc=0x100, ifid_valid=0, ifid_inst=0xE1A00000; flush_cnt=1; stall_cnt unchanged.
- Memory wait: imem_rdy=0 for 2 cycles at pc=0x20 -> PC holds 0x20; ifid_valid=0 for 2 cycles; wait_cnt=2; inst@0x20 enters IF/ID when imem_rdy returns to 1.
- Wrap and saturation: RESET_PC=0xFFFF_FFFC with CNT_W=2 -> PC goes 0xFFFFFFFC then 0x0; stall held 5 cycles gives stall_cnt=3.
- Reset mid-stall: rst pulsed during an active stall with ifid_valid=1 -> all outputs return to reset values the next cycle; the BOOT cycle repeats.

Source files
------------

// File: rtl/arm_fe_pkg.sv
// rtl/arm_fe_pkg.sv - shared front-end constants and state type
package arm_fe_pkg;

    localparam logic [31:0] NOP_INST         = 32'hE1A0_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        BOOT  = 1'b0,
        FETCH = 1'b1
    } fe_state_t;

endpackage

// File: rtl/if_stage_ctrl_if.sv
// rtl/if_stage_ctrl_if.sv - instruction-memory read port bundle
interface if_stage_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd;
    logic [31:0]       imem_data;
    logic              imem_rdy;

    modport master (output imem_addr, output imem_rd, input imem_data, input imem_rdy);
    modport slave  (input imem_addr, input imem_rd, output imem_data, output imem_rdy);
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;
endmodule

// File: rtl/if_stage_ctrl.sv
// rtl/if_stage_ctrl.sv - fetch controller owning the PC and IF/ID register
module if_stage_ctrl
    import arm_fe_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_write,
    input  logic              ifid_write,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    if_stage_ctrl_if.master   imem,
    output logic              ifid_valid,
    output logic [31:0]       ifid_inst,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  wait_cnt
);
    fe_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [31:0]       ifid_inst_q, ifid_inst_d;
    logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
    logic              flush_inc, wait_inc, stall_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_inst_q  <= NOP_INST;
            ifid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

    // BOOT is a single quiet cycle; FETCH is left only through reset.
    always_comb begin
        state_d      = FETCH;
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pc_d    = ifid_pc_q;
        flush_inc    = 1'b0;
        wait_inc     = 1'b0;
        if (state_q == FETCH) begin
            if (branch_taken) begin
                pc_d         = {branch_target[ADDR_W-1:2], 2'b00};
                ifid_valid_d = 1'b0;
                ifid_inst_d  = NOP_INST;
                flush_inc    = 1'b1;
            end else begin
                if (pc_write) begin
                    if (imem.imem_rdy) begin
                        pc_d = pc_q + ADDR_W'(4);
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
                // IF/ID loads whatever the port delivers this cycle, or a bubble if refused.
                if (ifid_write) begin
                    if (imem.imem_rdy) begin
                        ifid_valid_d = 1'b1;
                        ifid_inst_d  = imem.imem_data;
                        ifid_pc_d    = pc_q;
                    end else begin
                        ifid_valid_d = 1'b0;
                        ifid_inst_d  = NOP_INST;
                    end
                end
            end
        end
    end

    assign stall_inc = stall & ~branch_taken;

    sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stall_inc), .count(stall_cnt));
    sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flush_inc), .count(flush_cnt));
    sat_counter #(.W(CNT_W)) u_wait_cnt  (.clk(clk), .rst(rst), .inc(wait_inc),  .count(wait_cnt));

    assign imem.imem_addr = pc_q;
    assign imem.imem_rd   = (state_q == FETCH);
    assign ifid_valid     = ifid_valid_q;
    assign ifid_inst      = ifid_inst_q;
    assign ifid_pc        = ifid_pc_q;
endmodule

// File: tb/tb_if_stage_ctrl.sv
// tb/tb_if_stage_ctrl.sv - directed self-checking bench for if_stage_ctrl
module tb_if_stage_ctrl;
    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst1 = 1'b1;
    logic        pc_write = 1'b1, ifid_write = 1'b1, stall = 1'b0;
    logic        branch_taken = 1'b0, rdy = 1'b1;
    logic [31:0] branch_target = '0;

    logic        v0, v1;
    logic [31:0] inst0, inst1, ipc0, ipc1;
    logic [31:0] sc0, fc0, wc0;
    logic [1:0]  sc1, fc1, wc1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    if_stage_ctrl_if #(.ADDR_W(32)) bus0 ();
    if_stage_ctrl_if #(.ADDR_W(32)) bus1 ();
    assign bus0.imem_data = mem(bus0.imem_addr);
    assign bus0.imem_rdy  = rdy;
    assign bus1.imem_data = mem(bus1.imem_addr);
    assign bus1.imem_rdy  = rdy;

    if_stage_ctrl dut0 (
        .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .imem(bus0.master),
        .ifid_valid(v0), .ifid_inst(inst0), .ifid_pc(ipc0),
        .stall_cnt(sc0), .flush_cnt(fc0), .wait_cnt(wc0)
    );

    if_stage_ctrl #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst1), .pc_write(pc_write), .ifid_write(ifid_write), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .imem(bus1.master),
        .ifid_valid(v1), .ifid_inst(inst1), .ifid_pc(ipc1),
        .stall_cnt(sc1), .flush_cnt(fc1), .wait_cnt(wc1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        checks++; if (bus0.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=%h", bus0.imem_addr, 32'h0); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", v0); end
        checks++; if (inst0 !== NOP) begin errors++; $display("FAIL rst_inst got=%h exp=%h", inst0, NOP); end
        checks++; if (ipc0 !== 32'h0) begin errors++; $display("FAIL rst_ifid_pc got=%h exp=0", ipc0); end
        checks++; if ({sc0, fc0, wc0} !== 96'h0) begin errors++; $display("FAIL rst_cnt got=%h/%h/%h exp=0", sc0, fc0, wc0); end
        rst = 1'b0;
        checks++; if (bus0.imem_rd !== 1'b0) begin errors++; $display("FAIL boot_rd got=%b exp=0", bus0.imem_rd); end
        tick();
        checks++; if (bus0.imem_rd !== 1'b1) begin errors++; $display("FAIL fetch_rd got=%b exp=1", bus0.imem_rd); end
        checks++; if (bus0.imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got=%h exp=0", bus0.imem_addr); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL boot_valid got=%b exp=0", v0); end
        tick();
        checks++; if (bus0.imem_addr !== 32'h4) begin errors++; $display("FAIL pc_seq4 got=%h exp=4", bus0.imem_addr); end
        checks++; if ({v0, inst0, ipc0} !== {1'b1, mem(32'h0), 32'h0}) begin errors++; $display("FAIL ifid0 got=%b/%h/%h exp=1/%h/0", v0, inst0, ipc0, mem(32'h0)); end
        tick();
        checks++; if (bus0.imem_addr !== 32'h8) begin errors++; $display("FAIL pc_seq8 got=%h exp=8", bus0.imem_addr); end
        checks++; if (ipc0 !== 32'h4) begin errors++; $display("FAIL ifid_pc4 got=%h exp=4", ipc0); end
    endtask

    task automatic test_load_use();
        pc_write = 1'b0; ifid_write = 1'b0; stall = 1'b1;
        tick();
        checks++; if (bus0.imem_addr !== 32'h8) begin errors++; $display("FAIL lu_pc got=%h exp=8", bus0.imem_addr); end
        checks++; if ({v0, inst0, ipc0} !== {1'b1, mem(32'h4), 32'h4}) begin errors++; $display("FAIL lu_ifid got=%b/%h/%h exp=1/%h/4", v0, inst0, ipc0, mem(32'h4)); end
        checks++; if (sc0 !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", sc0); end
        pc_write = 1'b1; ifid_write = 1'b1; stall = 1'b0;
        tick();
        checks++; if ({ipc0, inst0, bus0.imem_addr} !== {32'h8, mem(32'h8), 32'hC}) begin errors++; $display("FAIL lu_resume got=%h/%h/%h exp=8/%h/c", ipc0, inst0, bus0.imem_addr, mem(32'h8)); end
    endtask

    task automatic test_branch_stall();
        pc_write = 1'b0; ifid_write = 1'b0; stall = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h0000_0102;
        tick();
        checks++; if (bus0.imem_addr !== 32'h100) begin errors++; $display("FAIL br_pc got=%h exp=100", bus0.imem_addr); end
        checks++; if ({v0, inst0} !== {1'b0, NOP}) begin errors++; $display("FAIL br_flush got=%b/%h exp=0/%h", v0, inst0, NOP); end
        checks++; if (fc0 !== 32'd1) begin errors++; $display("FAIL br_flush_cnt got=%0d exp=1", fc0); end
        checks++; if (sc0 !== 32'd1) begin errors++; $display("FAIL br_stall_cnt got=%0d exp=1", sc0); end
        branch_taken = 1'b0; pc_write = 1'b1; ifid_write = 1'b1; stall = 1'b0;
        tick();
        checks++; if ({v0, ipc0, bus0.imem_addr} !== {1'b1, 32'h100, 32'h104}) begin errors++; $display("FAIL br_next got=%b/%h/%h exp=1/100/104", v0, ipc0, bus0.imem_addr); end
    endtask

    task automatic test_mem_wait();
        branch_taken = 1'b1; branch_target = 32'h20;
        tick();
        branch_taken = 1'b0; rdy = 1'b0;
        checks++; if ({bus0.imem_addr, fc0} !== {32'h20, 32'd2}) begin errors++; $display("FAIL mw_setup got=%h/%0d exp=20/2", bus0.imem_addr, fc0); end
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++; if ({v0, bus0.imem_addr, wc0} !== {1'b0, 32'h20, 32'(i)}) begin errors++; $display("FAIL mw_hold%0d got=%b/%h/%0d exp=0/20/%0d", i, v0, bus0.imem_addr, wc0, i); end
        end
        rdy = 1'b1;
        tick();
        checks++; if ({v0, inst0, ipc0, bus0.imem_addr} !== {1'b1, mem(32'h20), 32'h20, 32'h24}) begin errors++; $display("FAIL mw_resume got=%b/%h/%h/%h exp=1/%h/20/24", v0, inst0, ipc0, bus0.imem_addr, mem(32'h20)); end
        ifid_write = 1'b0;
        tick();
        checks++; if ({ipc0, bus0.imem_addr} !== {32'h20, 32'h28}) begin errors++; $display("FAIL drop got=%h/%h exp=20/28", ipc0, bus0.imem_addr); end
        ifid_write = 1'b1;
    endtask

    task automatic test_wrap_sat();
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        checks++; if (bus1.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_rst got=%h exp=fffffffc", bus1.imem_addr); end
        tick();
        checks++; if (bus1.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_boot got=%h exp=fffffffc", bus1.imem_addr); end
        tick();
        checks++; if ({bus1.imem_addr, ipc1} !== {32'h0, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap got=%h/%h exp=0/fffffffc", bus1.imem_addr, ipc1); end
        pc_write = 1'b0; ifid_write = 1'b0; stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (sc1 !== 2'd3) begin errors++; $display("FAIL sat got=%0d exp=3", sc1); end
        checks++; if (sc0 !== 32'd6) begin errors++; $display("FAIL stall_cnt6 got=%0d exp=6", sc0); end
    endtask

    task automatic test_reset_mid_stall();
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got=%b exp=1", v0); end
        rst = 1'b1;
        tick();
        checks++; if ({bus0.imem_addr, v0, inst0, ipc0} !== {32'h0, 1'b0, NOP, 32'h0}) begin errors++; $display("FAIL mid_rst got=%h/%b/%h/%h", bus0.imem_addr, v0, inst0, ipc0); end
        checks++; if ({sc0, fc0, wc0} !== 96'h0) begin errors++; $display("FAIL mid_rst_cnt got=%0d/%0d/%0d exp=0", sc0, fc0, wc0); end
        rst = 1'b0; stall = 1'b0; pc_write = 1'b1; ifid_write = 1'b1;
        checks++; if (bus0.imem_rd !== 1'b0) begin errors++; $display("FAIL reboot_rd got=%b exp=0", bus0.imem_rd); end
        tick();
        checks++; if ({bus0.imem_rd, bus0.imem_addr, v0} !== {1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL reboot_fetch got=%b/%h/%b exp=1/0/0", bus0.imem_rd, bus0.imem_addr, v0); end
        tick();
        checks++; if ({v0, ipc0, bus0.imem_addr} !== {1'b1, 32'h0, 32'h4}) begin errors++; $display("FAIL reboot_ifid got=%b/%h/%h exp=1/0/4", v0, ipc0, bus0.imem_addr); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_stall();
        test_mem_wait();
        test_wrap_sat();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
